// File: rtl/fp_writeback_arbiter_if.sv
// Writeback-arbiter bus bundle: issue/scoreboard, FPU and load result inputs, register-file write port.
// The FP_WB_FWD_EN macro adds the early-forwarding signals fwd_valid_o/fwd_rd_o/fwd_data_o.
interface fp_writeback_arbiter_if;
  logic        issue_valid_i;
  logic [4:0]  issue_frd_i;
  logic [31:0] busy_o;
  logic        fpu_valid_i;
  logic        fpu_ready_o;
  logic [4:0]  fpu_rd_i;
  logic [31:0] fpu_data_i;
  logic [4:0]  fpu_fflags_i;
  logic        ld_valid_i;
  logic        ld_ready_o;
  logic [4:0]  ld_rd_i;
  logic [31:0] ld_data_i;
  logic        fflags_clr_i;
  logic [4:0]  fflags_o;
  logic        fregwrite_o;
  logic [4:0]  frd_o;
  logic [31:0] writeback_data_o;
`ifdef FP_WB_FWD_EN
  logic        fwd_valid_o;
  logic [4:0]  fwd_rd_o;
  logic [31:0] fwd_data_o;

  modport slave (
    input  issue_valid_i, issue_frd_i, fpu_valid_i, fpu_rd_i, fpu_data_i, fpu_fflags_i,
           ld_valid_i, ld_rd_i, ld_data_i, fflags_clr_i,
    output busy_o, fpu_ready_o, ld_ready_o, fflags_o, fregwrite_o, frd_o, writeback_data_o,
           fwd_valid_o, fwd_rd_o, fwd_data_o
  );
  modport master (
    output issue_valid_i, issue_frd_i, fpu_valid_i, fpu_rd_i, fpu_data_i, fpu_fflags_i,
           ld_valid_i, ld_rd_i, ld_data_i, fflags_clr_i,
    input  busy_o, fpu_ready_o, ld_ready_o, fflags_o, fregwrite_o, frd_o, writeback_data_o,
           fwd_valid_o, fwd_rd_o, fwd_data_o
  );
`else
  modport slave (
    input  issue_valid_i, issue_frd_i, fpu_valid_i, fpu_rd_i, fpu_data_i, fpu_fflags_i,
           ld_valid_i, ld_rd_i, ld_data_i, fflags_clr_i,
    output busy_o, fpu_ready_o, ld_ready_o, fflags_o, fregwrite_o, frd_o, writeback_data_o
  );
  modport master (
    output issue_valid_i, issue_frd_i, fpu_valid_i, fpu_rd_i, fpu_data_i, fpu_fflags_i,
           ld_valid_i, ld_rd_i, ld_data_i, fflags_clr_i,
    input  busy_o, fpu_ready_o, ld_ready_o, fflags_o, fregwrite_o, frd_o, writeback_data_o
  );
`endif
endinterface

// File: rtl/fp_writeback_arbiter.sv
// FP writeback arbiter: merges load data and FIFO-buffered FPU results into the FP register-file
// write port, tracks pending destinations and sticky FPU flags. FP_WB_FWD_EN adds early forwarding.
module fp_writeback_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  fp_writeback_arbiter_if.slave wb
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_DEPTH = DEPTH[AW:0];
  localparam logic [3:0]  LP_LIMIT = STARVE_LIMIT[3:0];

  logic [4:0]  r_mem_rd    [DEPTH];
  logic [31:0] r_mem_data  [DEPTH];
  logic [4:0]  r_mem_flags [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic [3:0]    r_starve;
  logic          r_fregwrite;
  logic [4:0]    r_frd;
  logic [31:0]   r_data;
  logic [4:0]    r_fflags;
  logic [31:0]   r_busy;

  logic w_empty, w_full, w_force, w_ld_ready, w_fpu_ready, w_ld_fire, w_fpu_fire;
  logic w_push, w_pop;
  logic        w_win_valid, w_win_fpu;
  logic [4:0]  w_win_rd, w_win_flags;
  logic [31:0] w_win_data;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == LP_DEPTH);
  // Once the FIFO head has lost STARVE_LIMIT times in a row, the load is refused for a cycle.
  assign w_force     = !w_empty && (r_starve == LP_LIMIT);
  assign w_ld_ready  = !rst_i && !w_force;
  assign w_fpu_ready = !rst_i && !w_full;
  assign w_ld_fire   = wb.ld_valid_i && w_ld_ready;
  assign w_fpu_fire  = wb.fpu_valid_i && w_fpu_ready;

  always_comb begin
    w_win_valid = 1'b0;
    w_win_fpu   = 1'b0;
    w_win_rd    = '0;
    w_win_data  = '0;
    w_win_flags = '0;
    w_pop       = 1'b0;
    w_push      = w_fpu_fire;
    if (w_ld_fire) begin
      w_win_valid = 1'b1;
      w_win_rd    = wb.ld_rd_i;
      w_win_data  = wb.ld_data_i;
    end else if (!w_empty) begin
      w_win_valid = 1'b1;
      w_win_fpu   = 1'b1;
      w_win_rd    = r_mem_rd[r_rd_ptr];
      w_win_data  = r_mem_data[r_rd_ptr];
      w_win_flags = r_mem_flags[r_rd_ptr];
      w_pop       = 1'b1;
    end else if (w_fpu_fire) begin
      // Empty FIFO and no load: the incoming result skips the buffer entirely.
      w_win_valid = 1'b1;
      w_win_fpu   = 1'b1;
      w_win_rd    = wb.fpu_rd_i;
      w_win_data  = wb.fpu_data_i;
      w_win_flags = wb.fpu_fflags_i;
      w_push      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_rd[r_wr_ptr]    <= wb.fpu_rd_i;
      r_mem_data[r_wr_ptr]  <= wb.fpu_data_i;
      r_mem_flags[r_wr_ptr] <= wb.fpu_fflags_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_starve <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      r_starve <= (!w_empty && w_ld_fire) ? r_starve + 4'd1 : 4'd0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fregwrite <= 1'b0;
      r_frd       <= '0;
      r_data      <= '0;
      r_fflags    <= '0;
    end else begin
      r_fregwrite <= w_win_valid;
      r_frd       <= w_win_rd;
      r_data      <= w_win_data;
      if (wb.fflags_clr_i)
        r_fflags <= w_win_fpu ? w_win_flags : 5'd0;
      else if (w_win_fpu)
        r_fflags <= r_fflags | w_win_flags;
    end
  end

  // Busy bit clears on the register-file write edge; a same-cycle reissue keeps it set.
  for (genvar gi = 0; gi < 32; gi++) begin : g_busy
    logic w_set, w_clr;
    assign w_set = wb.issue_valid_i && (wb.issue_frd_i == 5'(gi));
    assign w_clr = r_fregwrite && (r_frd == 5'(gi));
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)      r_busy[gi] <= 1'b0;
      else if (w_set) r_busy[gi] <= 1'b1;
      else if (w_clr) r_busy[gi] <= 1'b0;
    end
  end

  a_issue_not_busy: assert property (@(posedge clk_i) disable iff (rst_i)
    wb.issue_valid_i |-> (!r_busy[wb.issue_frd_i] || (r_fregwrite && r_frd == wb.issue_frd_i)));

  assign wb.busy_o           = r_busy;
  assign wb.fpu_ready_o      = w_fpu_ready;
  assign wb.ld_ready_o       = w_ld_ready;
  assign wb.fflags_o         = r_fflags;
  assign wb.fregwrite_o      = r_fregwrite;
  assign wb.frd_o            = r_frd;
  assign wb.writeback_data_o = r_data;

`ifdef FP_WB_FWD_EN
  assign wb.fwd_valid_o = w_win_valid;
  assign wb.fwd_rd_o    = w_win_rd;
  assign wb.fwd_data_o  = w_win_data;
`endif
endmodule

// File: tb/tb_fp_writeback_arbiter.sv
// Directed bench for fp_writeback_arbiter: expected writes go into a scoreboard queue and a
// negedge monitor pops and compares every register-file write.
module tb_fp_writeback_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_writeback_arbiter_if wb();
  fp_writeback_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (.clk_i(clk), .rst_i(rst), .wb(wb));

  typedef struct packed {logic [4:0] rd; logic [31:0] data;} wr_t;
  typedef struct packed {logic [4:0] rd; logic [31:0] data; logic [4:0] flags;} stim_t;

  int checks = 0;
  int failures = 0;
  wr_t exp_q[$];
  wr_t mon_e;
  stim_t ld_stim[$];
  stim_t fpu_stim[$];
  bit exp_ldr [13] = '{1,1,1,1,1,0,1,1,1,1,0,1,1};
  bit exp_fpr [13] = '{1,1,0,0,0,0,1,0,0,0,0,1,1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wb.issue_valid_i = 1'b0; wb.issue_frd_i  = '0;
    wb.fpu_valid_i   = 1'b0; wb.fpu_rd_i     = '0; wb.fpu_data_i = '0; wb.fpu_fflags_i = '0;
    wb.ld_valid_i    = 1'b0; wb.ld_rd_i      = '0; wb.ld_data_i  = '0;
    wb.fflags_clr_i  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fpu(input logic [4:0] rd, input logic [31:0] data, input logic [4:0] fl);
    wb.fpu_valid_i = 1'b1; wb.fpu_rd_i = rd; wb.fpu_data_i = data; wb.fpu_fflags_i = fl;
  endtask

  task automatic drive_ld(input logic [4:0] rd, input logic [31:0] data);
    wb.ld_valid_i = 1'b1; wb.ld_rd_i = rd; wb.ld_data_i = data;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back('{rd: rd, data: data});
  endtask

  // Monitor: every write the DUT presents must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && wb.fregwrite_o) begin
      $display("WB rd=%0d data=0x%08h", wb.frd_o, wb.writeback_data_o);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_unexpected actual rd=%0d data=0x%08h required no write",
                 wb.frd_o, wb.writeback_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_rd", 32'(wb.frd_o), 32'(mon_e.rd));
        chk("wb_data", wb.writeback_data_o, mon_e.data);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_fregwrite", 32'(wb.fregwrite_o), 32'd0);
    chk("rst_fpu_ready", 32'(wb.fpu_ready_o), 32'd0);
    chk("rst_busy", wb.busy_o, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_fpu_ready", 32'(wb.fpu_ready_o), 32'd1);
    chk("idle_ld_ready", 32'(wb.ld_ready_o), 32'd1);
    chk("idle_fregwrite", 32'(wb.fregwrite_o), 32'd0);
    chk("idle_frd", 32'(wb.frd_o), 32'd0);
    chk("idle_data", wb.writeback_data_o, 32'd0);
    chk("idle_fflags", 32'(wb.fflags_o), 32'd0);

    // Lone FPU result with its scoreboard entry.
    tick(); wb.issue_valid_i = 1'b1; wb.issue_frd_i = 5'd3;
    tick(); idle_inputs(); drive_fpu(5'd3, 32'h3F80_0000, 5'b00001); expect_wr(5'd3, 32'h3F80_0000);
    @(negedge clk);
    chk("busy3_set", 32'(wb.busy_o[3]), 32'd1);
    tick(); idle_inputs();
    @(negedge clk);
    chk("lone_fregwrite", 32'(wb.fregwrite_o), 32'd1);
    chk("busy3_during_write", 32'(wb.busy_o[3]), 32'd1);
    chk("lone_fflags", 32'(wb.fflags_o), 32'd1);
    tick();
    @(negedge clk);
    chk("busy3_cleared", 32'(wb.busy_o[3]), 32'd0);

    // Load and FPU together, FIFO empty: load first, FPU one cycle later.
    tick(); drive_ld(5'd5, 32'h1111_1111); drive_fpu(5'd6, 32'h4000_0000, 5'b00010);
    expect_wr(5'd5, 32'h1111_1111); expect_wr(5'd6, 32'h4000_0000);
    tick(); idle_inputs();
    tick(); tick();
    @(negedge clk);
    chk("pair_fflags", 32'(wb.fflags_o), 32'h3);
    chk("pair_fifo_empty_ready", 32'(wb.fpu_ready_o), 32'd1);

    // Starvation and FIFO-full: continuous loads against three FPU results.
    for (int i = 10; i <= 19; i++) ld_stim.push_back('{rd: 5'(i), data: 32'hA000_0000 + 32'(i), flags: 5'd0});
    for (int i = 20; i <= 22; i++) fpu_stim.push_back('{rd: 5'(i), data: 32'hB000_0000 + 32'(i), flags: 5'd0});
    for (int i = 10; i <= 14; i++) expect_wr(5'(i), 32'hA000_0000 + 32'(i));
    expect_wr(5'd20, 32'hB000_0014);
    for (int i = 15; i <= 18; i++) expect_wr(5'(i), 32'hA000_0000 + 32'(i));
    expect_wr(5'd21, 32'hB000_0015);
    expect_wr(5'd19, 32'hA000_0013);
    expect_wr(5'd22, 32'hB000_0016);
    for (int c = 0; c < 13; c++) begin
      tick();
      idle_inputs();
      if (ld_stim.size() > 0)  drive_ld(ld_stim[0].rd, ld_stim[0].data);
      if (fpu_stim.size() > 0) drive_fpu(fpu_stim[0].rd, fpu_stim[0].data, fpu_stim[0].flags);
      #1;
      chk($sformatf("starve_ld_ready_c%0d", c), 32'(wb.ld_ready_o), 32'(exp_ldr[c]));
      chk($sformatf("starve_fpu_ready_c%0d", c), 32'(wb.fpu_ready_o), 32'(exp_fpr[c]));
      if (wb.ld_valid_i && wb.ld_ready_o)   void'(ld_stim.pop_front());
      if (wb.fpu_valid_i && wb.fpu_ready_o) void'(fpu_stim.pop_front());
    end
    chk("starve_ld_drained", 32'(ld_stim.size()), 32'd0);
    chk("starve_fpu_drained", 32'(fpu_stim.size()), 32'd0);
    tick(); idle_inputs();
    repeat (3) tick();

    // Same-cycle busy set/clear of register 7.
    wb.issue_valid_i = 1'b1; wb.issue_frd_i = 5'd7;
    tick(); idle_inputs(); drive_ld(5'd7, 32'hC000_0007); expect_wr(5'd7, 32'hC000_0007);
    tick(); idle_inputs(); wb.issue_valid_i = 1'b1; wb.issue_frd_i = 5'd7;
    @(negedge clk);
    chk("busy7_write_cycle", 32'(wb.busy_o[7]), 32'd1);
    tick(); idle_inputs();
    @(negedge clk);
    chk("busy7_set_wins", 32'(wb.busy_o[7]), 32'd1);

    // Flag clear together with an NV contribution.
    tick(); drive_fpu(5'd8, 32'h7FC0_0000, 5'b10000); wb.fflags_clr_i = 1'b1;
    expect_wr(5'd8, 32'h7FC0_0000);
    tick(); idle_inputs();
    @(negedge clk);
    chk("clr_with_nv", 32'(wb.fflags_o), 32'h10);

    // Reset in the middle of a burst that has filled the FIFO.
    tick(); drive_ld(5'd1, 32'hD000_0001); drive_fpu(5'd30, 32'hE000_001E, 5'b00100);
    expect_wr(5'd1, 32'hD000_0001);
    tick(); drive_ld(5'd2, 32'hD000_0002); drive_fpu(5'd31, 32'hE000_001F, 5'b00100);
    tick(); idle_inputs(); rst = 1'b1;
    #1;
    chk("arst_fregwrite", 32'(wb.fregwrite_o), 32'd0);
    chk("arst_frd", 32'(wb.frd_o), 32'd0);
    chk("arst_data", wb.writeback_data_o, 32'd0);
    chk("arst_busy", wb.busy_o, 32'd0);
    chk("arst_fflags", 32'(wb.fflags_o), 32'd0);
    chk("arst_ld_ready", 32'(wb.ld_ready_o), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_fpu_ready", 32'(wb.fpu_ready_o), 32'd1);
    chk("post_rst_ld_ready", 32'(wb.ld_ready_o), 32'd1);
    repeat (4) tick();
    @(negedge clk);
    chk("post_rst_no_write", 32'(wb.fregwrite_o), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
